timer_bcd_counter: RTL

TIMER_BCD_COUNTER -- requirements
Module: timer_bcd_counter

---
 rtl/timer_pkg.sv | 68 ++++++
 rtl/timer_bcd_counter_if.sv | 23 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/timer_bcd_counter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types, limits and BCD MM:SS helpers for the countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_e;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t min_tens;
        bcd_digit_t min_units;
        bcd_digit_t sec_tens;
        bcd_digit_t sec_units;
    } mmss_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;
    localparam mmss_t      MMSS_ZERO    = 16'h0000;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input bcd_digit_t lim);
        bcd_digit_t r;
        if (d > lim) begin
            r = lim;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Seconds tens saturates at 5 directly, which also covers any nibble above 9.
    function automatic mmss_t clamp_mmss(input mmss_t v);
        mmss_t r;
        r.min_tens  = clamp_digit(v.min_tens,  DIGIT_MAX);
        r.min_units = clamp_digit(v.min_units, DIGIT_MAX);
        r.sec_tens  = clamp_digit(v.sec_tens,  SEC_TENS_MAX);
        r.sec_units = clamp_digit(v.sec_units, DIGIT_MAX);
        return r;
    endfunction

    function automatic mmss_t dec_mmss(input mmss_t v);
        mmss_t r;
        r = v;
        if (v == MMSS_ZERO) begin
            r = MMSS_ZERO;
        end else if (v.sec_units != 4'd0) begin
            r.sec_units = v.sec_units - 4'd1;
        end else begin
            r.sec_units = DIGIT_MAX;
            if (v.sec_tens != 4'd0) begin
                r.sec_tens = v.sec_tens - 4'd1;
            end else begin
                r.sec_tens = SEC_TENS_MAX;
                if (v.min_units != 4'd0) begin
                    r.min_units = v.min_units - 4'd1;
                end else begin
                    r.min_units = DIGIT_MAX;
                    r.min_tens  = v.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_bcd_counter_if.sv
// Command and display bundle between a controller and the countdown timer.
interface timer_bcd_counter_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        set_en;
    logic [15:0] set_val;
    logic [15:0] digits;
    logic        running;
    logic        paused;
    logic        done;
    logic        expired;

    modport master (
        output start, stop, clear, set_en, set_val,
        input  digits, running, paused, done, expired
    );

    modport slave (
        input  start, stop, clear, set_en, set_val,
        output digits, running, paused, done, expired
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; holds its count while disabled.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_r;

    // Count register: cleared on reset or request, advances only while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = en && !clr && (count_r == LAST);

endmodule

// File: rtl/timer_bcd_counter.sv
// MM:SS BCD countdown timer with run/pause/done control and registered outputs.
// Optional build macro TIMER_AUTO_RELOAD_EN reloads the preset on expiry instead of stopping.
module timer_bcd_counter
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    timer_bcd_counter_if.slave  bus
);

    timer_state_e state_r, state_s;
    mmss_t        digits_r, digits_s;
    mmss_t        preset_r, preset_s;
    logic         expired_r, expired_s;
    logic         running_r, paused_r, done_r;

    mmss_t        set_clamped_s;
    mmss_t        dec_s;
    logic         start_go_s;
    logic         stop_go_s;
    logic         presc_en_s;
    logic         presc_clr_s;
    logic         tick_s;

    assign set_clamped_s = clamp_mmss(mmss_t'(bus.set_val));
    assign dec_s         = dec_mmss(digits_r);

    // set_en in RUN is ignored but still outranks stop, so the countdown keeps going.
    assign stop_go_s  = bus.stop && !bus.set_en && !bus.clear;
    assign start_go_s = bus.start && !bus.stop && !bus.set_en && !bus.clear;
    assign presc_en_s = (state_r == ST_RUN) && !bus.clear && !(bus.stop && !bus.set_en);
    assign presc_clr_s = bus.clear
                       || (start_go_s && (((state_r == ST_IDLE) && (digits_r != MMSS_ZERO))
                                          || (state_r == ST_DONE)));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en_s),
        .clr  (presc_clr_s),
        .tick (tick_s)
    );

    // Next-state and next-value decode in command priority order.
    always_comb begin
        state_s   = state_r;
        digits_s  = digits_r;
        preset_s  = preset_r;
        expired_s = 1'b0;
        if (bus.clear) begin
            state_s  = ST_IDLE;
            digits_s = preset_r;
        end else if (bus.set_en && (state_r != ST_RUN)) begin
            state_s  = ST_IDLE;
            preset_s = set_clamped_s;
            digits_s = set_clamped_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_go_s && (digits_r != MMSS_ZERO)) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop_go_s) begin
                        state_s = ST_PAUSE;
                    end else if (tick_s) begin
                        if (dec_s == MMSS_ZERO) begin
                            expired_s = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                            if (preset_r != MMSS_ZERO) begin
                                digits_s = preset_r;
                                state_s  = ST_RUN;
                            end else begin
                                digits_s = MMSS_ZERO;
                                state_s  = ST_DONE;
                            end
`else
                            digits_s = MMSS_ZERO;
                            state_s  = ST_DONE;
`endif
                        end else begin
                            digits_s = dec_s;
                        end
                    end else begin
                        digits_s = digits_r;
                    end
                end
                ST_PAUSE: begin
                    if (start_go_s) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (start_go_s) begin
                        digits_s = preset_r;
                        if (preset_r != MMSS_ZERO) begin
                            state_s = ST_RUN;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    digits_s = preset_r;
                end
            endcase
        end
    end

    // State and output registers; status flags decode the next state so they align with digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            digits_r  <= MMSS_ZERO;
            preset_r  <= MMSS_ZERO;
            expired_r <= 1'b0;
            running_r <= 1'b0;
            paused_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            digits_r  <= digits_s;
            preset_r  <= preset_s;
            expired_r <= expired_s;
            running_r <= (state_s == ST_RUN);
            paused_r  <= (state_s == ST_PAUSE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign bus.digits  = digits_r;
    assign bus.running = running_r;
    assign bus.paused  = paused_r;
    assign bus.done    = done_r;
    assign bus.expired = expired_r;

endmodule
